multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the 32-bit RISC-V core. It replaces single-cycle decoding with a sequenced fetch / decode / execute / memory / writeback flow over one shared ALU and one shared memory port. Each instruction class is walked through its own path. Memory accesses stall on a ready handshake. The block sits between the instruction register's opcode field and the datapath mux and enable controls.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_out_decode.sv | 117 +++++++++++
 rtl/multicycle_ctrl.sv | 94 +++++++++
 tb/tb_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state codes, opcodes and datapath select encodings.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXECR  = 4'd7,
        ST_EXECI  = 4'd8,
        ST_ALUWB  = 4'd9,
        ST_BRANCH = 4'd10,
        ST_UPPER  = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP = 4'd12
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_LUI, OP_AUIPC: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-output decode for multicycle_ctrl: {state, Op, BranchTaken, mem_ready} -> datapath controls.
// illegal_op is present only when CTRL_ILLEGAL_TRAP_EN is defined.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] Op,
    input  logic       BranchTaken,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       instr_done
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_ADD;
        ResultSrc  = RES_ALUOUT;
        instr_done = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif

        case (state_t'(state))
            ST_FETCH: begin
                // PC+4 goes straight from the ALU into PC while the IR captures the fetched word.
                MemRead   = 1'b1;
                AdrSrc    = 1'b0;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
`ifndef CTRL_ILLEGAL_TRAP_EN
                instr_done = !is_known_op(Op);
`endif
            end
            ST_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = RES_READDATA;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite   = 1'b1;
                AdrSrc     = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_UPPER: begin
                ALUSrcA = (Op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_ALUWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = RES_ALUOUT;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_BRANCH;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = BranchTaken;
                instr_done = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: illegal_op = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: state register and next-state logic; outputs come from ctrl_out_decode.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic       mem_ready,
    input  logic       BranchTaken,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       instr_done,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic [3:0] state_o
);

    state_t state;

    // Reset lands in IDLE asynchronously, and IDLE decodes to all-zero, so requests drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    case (Op)
                        OP_LOAD, OP_STORE: state <= ST_MEMADR;
                        OP_RTYPE:          state <= ST_EXECR;
                        OP_ITYPE:          state <= ST_EXECI;
                        OP_BRANCH:         state <= ST_BRANCH;
                        OP_LUI, OP_AUIPC:  state <= ST_UPPER;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:           state <= ST_TRAP;
`else
                        default:           state <= ST_FETCH;
`endif
                    endcase
                end
                // The IR is stable for the whole instruction, so Op can be sampled live here.
                ST_MEMADR: state <= (Op == OP_STORE) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:  if (mem_ready) state <= ST_MEMWB;
                ST_MEMWB:  state <= ST_FETCH;
                ST_MEMWR:  if (mem_ready) state <= ST_FETCH;
                ST_EXECR:  state <= ST_ALUWB;
                ST_EXECI:  state <= ST_ALUWB;
                ST_UPPER:  state <= ST_ALUWB;
                ST_ALUWB:  state <= ST_FETCH;
                ST_BRANCH: state <= ST_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                ST_TRAP:   state <= ST_TRAP;
`endif
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state;

    ctrl_out_decode u_out_decode (
        .state       (state),
        .Op          (Op),
        .BranchTaken (BranchTaken),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .AdrSrc      (AdrSrc),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ResultSrc   (ResultSrc),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_op  (illegal_op),
`endif
        .instr_done  (instr_done)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle state and control vectors against hand-written tables.
// Builds with or without CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Op;
    logic       mem_ready;
    logic       BranchTaken;
    logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, instr_done;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [3:0] state_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .mem_ready   (mem_ready),
        .BranchTaken (BranchTaken),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .AdrSrc      (AdrSrc),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ResultSrc   (ResultSrc),
        .instr_done  (instr_done),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_op  (illegal_op),
`endif
        .state_o     (state_o)
    );

    // {PCWrite,IRWrite,AdrSrc,MemRead,MemWrite,RegWrite}_ALUSrcA_ALUSrcB_ALUOp_ResultSrc_instr_done
    logic [14:0] ctl;
    assign ctl = {PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, instr_done};

    localparam logic [14:0] C_IDLE       = 15'b000000_00_00_00_00_0;
    localparam logic [14:0] C_FETCH_RDY  = 15'b110100_00_10_00_10_0;
    localparam logic [14:0] C_FETCH_WAIT = 15'b000100_00_10_00_10_0;
    localparam logic [14:0] C_DECODE     = 15'b000000_01_01_00_00_0;
`ifndef CTRL_ILLEGAL_TRAP_EN
    localparam logic [14:0] C_DECODE_NOP = 15'b000000_01_01_00_00_1;
`endif
    localparam logic [14:0] C_MEMADR     = 15'b000000_10_01_00_00_0;
    localparam logic [14:0] C_MEMRD      = 15'b001100_00_00_00_00_0;
    localparam logic [14:0] C_MEMWB      = 15'b000001_00_00_00_01_1;
    localparam logic [14:0] C_MEMWR_WAIT = 15'b001010_00_00_00_00_0;
    localparam logic [14:0] C_MEMWR_DONE = 15'b001010_00_00_00_00_1;
    localparam logic [14:0] C_EXECR      = 15'b000000_10_00_10_00_0;
    localparam logic [14:0] C_EXECI      = 15'b000000_10_01_10_00_0;
    localparam logic [14:0] C_LUI        = 15'b000000_11_01_00_00_0;
    localparam logic [14:0] C_AUIPC      = 15'b000000_01_01_00_00_0;
    localparam logic [14:0] C_ALUWB      = 15'b000001_00_00_00_00_1;
    localparam logic [14:0] C_BR_T       = 15'b100000_10_00_01_00_1;
    localparam logic [14:0] C_BR_N       = 15'b000000_10_00_01_00_1;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXECR = 4'd7;
    localparam logic [3:0] S_EXECI = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_UPPER = 4'd11;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP = 4'd12;
`endif

    localparam logic [6:0] LD = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, LU = 7'b0110111, AU = 7'b0010111, BAD = 7'b1111111;

    typedef struct packed {
        logic [6:0]  op;
        logic        mr;
        logic        bt;
        logic [3:0]  st;
        logic [14:0] ctl;
    } step_t;

    task automatic test_reset();
        rst_n = 1'b1; Op = 7'd0; mem_ready = 1'b1; BranchTaken = 1'b0;
        #2 rst_n = 1'b0;
        #1 total++;
        if ({state_o, ctl} !== {S_IDLE, C_IDLE}) begin
            bad++; $display("FAIL reset_assert: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_IDLE, C_IDLE);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 total++;
        if ({state_o, ctl} !== {S_IDLE, C_IDLE}) begin
            bad++; $display("FAIL reset_idle: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_IDLE, C_IDLE);
        end
        @(posedge clk); #1 total++;
        if ({state_o, ctl} !== {S_FETCH, C_FETCH_RDY}) begin
            bad++; $display("FAIL reset_first_fetch: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_FETCH, C_FETCH_RDY);
        end
    endtask

    task automatic test_load();
        step_t seq [7];
        seq = '{'{LD, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{LD, 1'b0, 1'b0, S_DECODE, C_DECODE},
                '{LD, 1'b0, 1'b0, S_MEMADR, C_MEMADR},
                '{LD, 1'b0, 1'b0, S_MEMRD,  C_MEMRD},
                '{LD, 1'b0, 1'b0, S_MEMRD,  C_MEMRD},
                '{LD, 1'b1, 1'b0, S_MEMRD,  C_MEMRD},
                '{LD, 1'b0, 1'b0, S_MEMWB,  C_MEMWB}};
        for (int i = 0; i < 7; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL load[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        step_t seq [5];
        seq = '{'{SW, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{SW, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{SW, 1'b1, 1'b0, S_MEMADR, C_MEMADR},
                '{SW, 1'b0, 1'b0, S_MEMWR,  C_MEMWR_WAIT},
                '{SW, 1'b1, 1'b0, S_MEMWR,  C_MEMWR_DONE}};
        for (int i = 0; i < 5; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL store[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        step_t seq [9];
        seq = '{'{RT, 1'b0, 1'b0, S_FETCH,  C_FETCH_WAIT},
                '{RT, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{RT, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{RT, 1'b1, 1'b0, S_EXECR,  C_EXECR},
                '{RT, 1'b1, 1'b0, S_ALUWB,  C_ALUWB},
                '{IT, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{IT, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{IT, 1'b1, 1'b0, S_EXECI,  C_EXECI},
                '{IT, 1'b1, 1'b0, S_ALUWB,  C_ALUWB}};
        for (int i = 0; i < 9; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL alu[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        step_t seq [6];
        seq = '{'{BR, 1'b1, 1'b1, S_FETCH,  C_FETCH_RDY},
                '{BR, 1'b1, 1'b1, S_DECODE, C_DECODE},
                '{BR, 1'b1, 1'b1, S_BRANCH, C_BR_T},
                '{BR, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{BR, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{BR, 1'b1, 1'b0, S_BRANCH, C_BR_N}};
        for (int i = 0; i < 6; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL branch[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        BranchTaken = 1'b0;
    endtask

    task automatic test_upper();
        step_t seq [8];
        seq = '{'{LU, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{LU, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{LU, 1'b1, 1'b0, S_UPPER,  C_LUI},
                '{LU, 1'b1, 1'b0, S_ALUWB,  C_ALUWB},
                '{AU, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{AU, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{AU, 1'b1, 1'b0, S_UPPER,  C_AUIPC},
                '{AU, 1'b1, 1'b0, S_ALUWB,  C_ALUWB}};
        for (int i = 0; i < 8; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL upper[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midwrite();
        step_t seq [3];
        seq = '{'{SW, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{SW, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{SW, 1'b1, 1'b0, S_MEMADR, C_MEMADR}};
        for (int i = 0; i < 3; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL midwr[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1 total++;
        if ({state_o, ctl} !== {S_MEMWR, C_MEMWR_WAIT}) begin
            bad++; $display("FAIL midwr_pending: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_MEMWR, C_MEMWR_WAIT);
        end
        rst_n = 1'b0;
        #1 total++;
        if ({state_o, ctl} !== {S_IDLE, C_IDLE}) begin
            bad++; $display("FAIL midwr_drop: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_IDLE, C_IDLE);
        end
        @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b1;
        #1 total++;
        if ({state_o, ctl} !== {S_IDLE, C_IDLE}) begin
            bad++; $display("FAIL midwr_idle: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_IDLE, C_IDLE);
        end
        @(posedge clk); #1 total++;
        if ({state_o, ctl} !== {S_FETCH, C_FETCH_RDY}) begin
            bad++; $display("FAIL midwr_refetch: state=%0d ctl=%b want state=%0d ctl=%b", state_o, ctl, S_FETCH, C_FETCH_RDY);
        end
    endtask

`ifdef CTRL_ILLEGAL_TRAP_EN
    task automatic test_illegal();
        step_t seq [5];
        seq = '{'{BAD, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{BAD, 1'b1, 1'b0, S_DECODE, C_DECODE},
                '{BAD, 1'b1, 1'b0, S_TRAP,   C_IDLE},
                '{BAD, 1'b1, 1'b0, S_TRAP,   C_IDLE},
                '{LD,  1'b1, 1'b0, S_TRAP,   C_IDLE}};
        for (int i = 0; i < 5; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({illegal_op, state_o, ctl} !== {(seq[i].st == S_TRAP), seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL illegal[%0d]: ill=%b state=%0d ctl=%b want state=%0d ctl=%b", i, illegal_op, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
    endtask
`else
    task automatic test_illegal();
        step_t seq [4];
        seq = '{'{BAD, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{BAD, 1'b1, 1'b0, S_DECODE, C_DECODE_NOP},
                '{IT,  1'b1, 1'b0, S_FETCH,  C_FETCH_RDY},
                '{IT,  1'b1, 1'b0, S_DECODE, C_DECODE}};
        for (int i = 0; i < 4; i++) begin
            Op = seq[i].op; mem_ready = seq[i].mr; BranchTaken = seq[i].bt;
            #1 total++;
            if ({state_o, ctl} !== {seq[i].st, seq[i].ctl}) begin
                bad++; $display("FAIL illegal[%0d]: state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, seq[i].st, seq[i].ctl);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_branch();
        test_upper();
        test_reset_midwrite();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
